// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the core's MEM stage
// and a DMA/debug master. The core wins by default. A starving DMA master is
// promoted after MAX_WAIT denied cycles, and a locked DMA burst is cut off
// after LOCK_MAX grants. Read data is steered back to the master that issued
// the read, one cycle after its grant.
// Parameter assumptions: MAX_WAIT >= 1 and LOCK_MAX >= 1.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  // core (MEM stage) port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // DMA / debug port
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // RAM port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  // pipeline freeze
  output logic          core_stall
);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;
  typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);
  // lock_cnt_q counts grants already given in this burst; when it reaches
  // LOCK_MAX-1 the grant in the current cycle is the LOCK_MAX-th one.
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

  state_t         state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [LCW-1:0] lock_cnt_q;
  logic           rd_pend_q;
  owner_t         rd_owner_q;

  // Zero-latency grant decision and RAM request mux.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (!RESET) begin
      if (state_q == ST_LOCKED) begin
        d_gnt = d_req;
      end else if (d_req && wait_cnt_q == WAIT_SAT) begin
        d_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else begin
        d_gnt = d_req;
      end
    end
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign m_en       = c_gnt | d_gnt;
  assign core_stall = c_req & ~c_gnt;
  assign c_rdata    = m_rdata;
  assign d_rdata    = m_rdata;
  assign c_rvalid   = ~RESET & rd_pend_q & (rd_owner_q == OWN_CORE);
  assign d_rvalid   = ~RESET & rd_pend_q & (rd_owner_q == OWN_DMA);

  // Lock FSM, anti-starvation counter and read-return tracking.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RESET) begin
      state_q    <= ST_OPEN;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_pend_q  <= m_en & ~m_we;
      rd_owner_q <= d_gnt ? OWN_DMA : OWN_CORE;

      if (d_gnt || !d_req) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_SAT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      case (state_q)
        ST_OPEN: begin
          // A single-grant limit leaves nothing to lock.
          if (d_gnt && d_lock && LOCK_MAX > 1) begin
            state_q    <= ST_LOCKED;
            lock_cnt_q <= LCW'(1);
          end
        end
        ST_LOCKED: begin
          if (!d_req || !d_lock) begin
            state_q    <= ST_OPEN;
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q    <= ST_OPEN;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_OPEN;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a reference model of the arbitration rules checks
// every cycle, and directed scenarios pin literal expectations.
module tb_dmem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;
  localparam int LOCK_MAX = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          c_req, c_we, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          core_stall;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .core_stall(core_stall)
  );

  always #5 CLK = ~CLK;

  // Simple synchronous RAM driven by the arbiter's RAM port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    m_rdata = '0;
  end
  always @(posedge CLK) begin
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else      m_rdata     <= ram[m_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic half();
    @(negedge CLK); #1;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // ---------------- reference model ----------------
  // Tracks how long the DMA master has been refused, whether a burst holds
  // the RAM and how many grants it has had, plus a shadow of RAM contents.
  int            mdl_denied = 0;
  bit            mdl_locked = 0;
  int            mdl_burst  = 0;
  bit            mdl_pend   = 0;
  bit            mdl_pdma   = 0;
  logic [DW-1:0] mdl_pdata  = '0;
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = '0;

  always @(negedge CLK) begin
    bit            ec, ed, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    ec = 0; ed = 0;
    if (!RESET) begin
      if (mdl_locked)                        ed = d_req;
      else if (d_req && mdl_denied >= MAX_WAIT) ed = 1;
      else if (c_req)                        ec = 1;
      else                                   ed = d_req;
    end
    ewe = ec ? c_we    : (ed ? d_we    : 1'b0);
    ea  = ec ? c_addr  : (ed ? d_addr  : '0);
    ewd = ec ? c_wdata : (ed ? d_wdata : '0);

    check("c_gnt",      c_gnt,      ec);
    check("d_gnt",      d_gnt,      ed);
    check("m_en",       m_en,       ec | ed);
    check("m_we",       m_we,       ewe);
    check("m_addr",     m_addr,     ea);
    check("m_wdata",    m_wdata,    ewd);
    check("core_stall", core_stall, c_req & ~ec);
    check("c_rvalid",   c_rvalid,   !RESET && mdl_pend && !mdl_pdma);
    check("d_rvalid",   d_rvalid,   !RESET && mdl_pend &&  mdl_pdma);
    if (!RESET && mdl_pend && !mdl_pdma) check("c_rdata", c_rdata, mdl_pdata);
    if (!RESET && mdl_pend &&  mdl_pdma) check("d_rdata", d_rdata, mdl_pdata);

    // advance to the state after the coming edge
    if (RESET) begin
      mdl_denied = 0; mdl_locked = 0; mdl_burst = 0; mdl_pend = 0;
    end else begin
      mdl_pend  = (ec | ed) && !ewe;
      mdl_pdma  = ed;
      mdl_pdata = mdl_mem[ea];
      if ((ec | ed) && ewe) mdl_mem[ea] = ewd;
      if (ed || !d_req) mdl_denied = 0;
      else if (mdl_denied < MAX_WAIT) mdl_denied++;
      if (!mdl_locked) begin
        if (ed && d_lock) begin
          mdl_burst  = 1;
          mdl_locked = (LOCK_MAX > 1);
        end
      end else if (!(d_req && d_lock)) begin
        mdl_locked = 0;
      end else begin
        mdl_burst++;
        if (mdl_burst == LOCK_MAX) mdl_locked = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit got;
    int run;
    bit seen_dma;

    RESET = 1;
    c_req = 1; c_we = 0; c_addr = 10'h010; c_wdata = '0;
    d_req = 1; d_we = 0; d_lock = 0; d_addr = 10'h020; d_wdata = '0;

    // Reset with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      half();
      check("rst_c_gnt",    c_gnt,    0);
      check("rst_d_gnt",    d_gnt,    0);
      check("rst_m_en",     m_en,     0);
      check("rst_c_rvalid", c_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      tick();
    end
    RESET = 0;
    half();
    check("post_rst_core_first", {c_gnt, d_gnt}, 2'b10);
    tick();
    c_req = 0; d_req = 0;
    tick();

    // Core write then read of address 5.
    c_req = 1; c_we = 1; c_addr = 10'h005; c_wdata = 32'hDEADBEEF;
    half();
    check("cwr_gnt", c_gnt, 1);
    tick();
    c_we = 0;
    half();
    check("crd_gnt",   c_gnt,      1);
    check("crd_stall", core_stall, 0);
    tick();
    c_req = 0;
    half();
    check("crd_rvalid", c_rvalid, 1);
    check("crd_rdata",  c_rdata,  32'hDEADBEEF);
    check("crd_drv",    d_rvalid, 0);
    tick();

    // Starvation: both request continuously; DMA wins on the 9th cycle.
    c_req = 1; c_we = 0; c_addr = 10'h007;
    d_req = 1; d_we = 1; d_lock = 0; d_addr = 10'h200; d_wdata = 32'h5555_0000;
    for (int i = 1; i <= 10; i++) begin
      half();
      if (i == 9) begin
        check("starve_dma_gnt", {c_gnt, d_gnt}, 2'b01);
        check("starve_stall",   core_stall,     1);
      end else begin
        check("starve_core_gnt", {c_gnt, d_gnt}, 2'b10);
      end
      tick();
    end
    c_req = 0; d_req = 0;
    tick();

    // Locked burst: DMA writes 0x100..0x103 while the core keeps requesting.
    c_req = 1; c_addr = 10'h008;
    d_req = 1; d_we = 1; d_lock = 1; d_addr = 10'h100; d_wdata = 32'hA0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      half();
      if (d_gnt) got = 1;
      else tick();
    end
    check("burst_start", got, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) half();
      check("burst_gnt",   d_gnt,      1);
      check("burst_stall", core_stall, 1);
      check("burst_addr",  m_addr,     10'h100 + k);
      tick();
      d_addr  = 10'h100 + AW'(k + 1);
      d_wdata = 32'hA0 + DW'(k + 1);
      if (k == 3) begin d_req = 0; d_lock = 0; end
    end
    half();
    check("burst_tail_no_cgnt", c_gnt,      0);
    check("burst_tail_stall",   core_stall, 1);
    tick();
    half();
    check("burst_core_resumes", c_gnt, 1);
    tick();
    c_req = 0;
    tick();

    // DMA reads back one of the burst words.
    d_req = 1; d_we = 0; d_addr = 10'h102;
    half();
    check("drd_gnt", d_gnt, 1);
    tick();
    d_req = 0;
    half();
    check("drd_rvalid", d_rvalid, 1);
    check("drd_rdata",  d_rdata,  32'hA2);
    check("drd_crv",    c_rvalid, 0);
    tick();

    // Lock bound: 40 cycles of locked DMA requests against a busy core.
    // Expect 8 core, 16 DMA, 8 core, then DMA again.
    c_req = 1; c_we = 0; c_addr = 10'h009;
    d_req = 1; d_we = 1; d_lock = 1; d_addr = 10'h300; d_wdata = 32'h77;
    run = 0; seen_dma = 0;
    for (int i = 0; i < 40; i++) begin
      bit exp_d;
      exp_d = (i >= 8 && i < 24) || (i >= 32);
      half();
      check("lockmax_pattern", {c_gnt, d_gnt}, exp_d ? 2'b01 : 2'b10);
      if (d_gnt && (!seen_dma || i < 24)) begin seen_dma = 1; run++; end
      tick();
    end
    check("lockmax_run", run, LOCK_MAX);
    c_req = 0; d_req = 0; d_lock = 0;
    tick();

    // Reset right after a locked DMA read grant.
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 10'h101;
    half();
    check("rmr_gnt", d_gnt, 1);
    tick();
    RESET = 1;
    half();
    check("rmr_drv_in_rst", d_rvalid, 0);
    tick();
    tick();
    RESET = 0;
    c_req = 1; c_we = 0; c_addr = 10'h005;
    half();
    check("rmr_open_core_wins", {c_gnt, d_gnt}, 2'b10);
    check("rmr_no_drv",         d_rvalid,       0);
    check("rmr_no_crv",         c_rvalid,       0);
    tick();
    c_req = 0; d_req = 0; d_lock = 0;
    for (int i = 0; i < 3; i++) begin
      half();
      check("rmr_quiet_drv", d_rvalid, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
